// File: rtl/event_timestamp_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | event_timestamp_logger: timestamps classifier changes into a FWFT FIFO   |
// | with saturating spike-onset and dropped-record diagnostics counters.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module event_timestamp_logger #(
  parameter int DEPTH       = 16,
  parameter int TS_WIDTH    = 32,
  parameter int EVENT_WIDTH = 32,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          spike_detection,
  input  logic [EVENT_WIDTH-1:0]        event_in,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [TS_WIDTH+EVENT_WIDTH-1:0] m_data,
  output logic [$clog2(DEPTH):0]        fifo_level,
  output logic [CNT_WIDTH-1:0]          spike_count,
  output logic [CNT_WIDTH-1:0]          overflow_count
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_REC_W  = TS_WIDTH + EVENT_WIDTH;
  localparam logic [c_ADDR_W:0] c_FULL = (c_ADDR_W + 1)'(DEPTH);

  logic [TS_WIDTH-1:0]    r_ts;
  logic [EVENT_WIDTH-1:0] r_prev_ev;
  logic                   r_prev_sp;
  logic [CNT_WIDTH-1:0]   r_spike_cnt;
  logic [CNT_WIDTH-1:0]   r_ovf_cnt;
  logic [c_ADDR_W-1:0]    r_wr_ptr;
  logic [c_ADDR_W-1:0]    r_rd_ptr;
  logic [c_ADDR_W:0]      r_level;
  logic [c_REC_W-1:0]     r_mem [DEPTH];

  logic w_valid;
  logic w_record;
  logic w_pop;
  logic w_full;
  logic w_push;
  logic w_drop;
  logic w_onset;

  assign w_valid  = (r_level != '0);
  assign w_record = (event_in != r_prev_ev);
  assign w_pop    = w_valid & m_ready;
  assign w_full   = (r_level == c_FULL);
  // A pop in the same cycle frees the slot the incoming record needs.
  assign w_push   = w_record & (~w_full | w_pop);
  assign w_drop   = w_record & w_full & ~w_pop;
  assign w_onset  = spike_detection & ~r_prev_sp;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ts        <= '0;
      r_prev_ev   <= '0;
      r_prev_sp   <= 1'b0;
      r_spike_cnt <= '0;
      r_ovf_cnt   <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_level     <= '0;
    end else begin
      r_ts      <= r_ts + 1'b1;
      r_prev_ev <= event_in;
      r_prev_sp <= spike_detection;
      if (w_onset && (r_spike_cnt != '1)) begin
        r_spike_cnt <= r_spike_cnt + 1'b1;
      end
      if (w_drop && (r_ovf_cnt != '1)) begin
        r_ovf_cnt <= r_ovf_cnt + 1'b1;
      end
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

  // Storage needs no reset; the head is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst && w_push) begin
      r_mem[r_wr_ptr] <= {r_ts, event_in};
    end
  end

  assign m_valid        = w_valid;
  assign m_data         = w_valid ? r_mem[r_rd_ptr] : '0;
  assign fifo_level     = r_level;
  assign spike_count    = r_spike_cnt;
  assign overflow_count = r_ovf_cnt;

endmodule
`default_nettype wire

// File: tb/tb_event_timestamp_logger.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_event_timestamp_logger: directed bench with queue-based reference.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_event_timestamp_logger;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        sp  = 1'b0;
  logic [31:0] ev  = '0;
  logic        rdy = 1'b0;
  logic        vld;
  logic [63:0] dat;
  logic [4:0]  lvl;
  logic [15:0] spk;
  logic [15:0] ovf;

  // Small instance for wrap/saturation corners that the default sizes make too long.
  logic        s_rst = 1'b0;
  logic        s_sp  = 1'b0;
  logic [7:0]  s_ev  = '0;
  logic        s_rdy = 1'b0;
  logic        s_vld;
  logic [15:0] s_dat;
  logic [2:0]  s_lvl;
  logic [3:0]  s_spk;
  logic [3:0]  s_ovf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  event_timestamp_logger dut (
    .clk(clk), .rst(rst), .spike_detection(sp), .event_in(ev),
    .m_valid(vld), .m_ready(rdy), .m_data(dat), .fifo_level(lvl),
    .spike_count(spk), .overflow_count(ovf)
  );

  event_timestamp_logger #(.DEPTH(4), .TS_WIDTH(8), .EVENT_WIDTH(8), .CNT_WIDTH(4)) dut_small (
    .clk(clk), .rst(s_rst), .spike_detection(s_sp), .event_in(s_ev),
    .m_valid(s_vld), .m_ready(s_rdy), .m_data(s_dat), .fifo_level(s_lvl),
    .spike_count(s_spk), .overflow_count(s_ovf)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: a queue of records plus plain counters.
  logic [63:0] mq[$];
  logic [31:0] m_ts;
  logic [31:0] m_prev_ev;
  logic        m_prev_sp;
  int          m_spk;
  int          m_ovf;
  bit          m_on = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      m_ts = 0; m_prev_ev = 0; m_prev_sp = 0; m_spk = 0; m_ovf = 0;
      m_on = 1'b1;
    end else if (m_on) begin
      if (mq.size() > 0 && rdy) void'(mq.pop_front());
      if (ev != m_prev_ev) begin
        if (mq.size() < 16) mq.push_back({m_ts, ev});
        else if (m_ovf < 65535) m_ovf++;
      end
      if (sp && !m_prev_sp && m_spk < 65535) m_spk++;
      m_prev_ev = ev;
      m_prev_sp = sp;
      m_ts      = m_ts + 32'd1;
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      chk("m_valid", 64'(vld), 64'(mq.size() > 0));
      chk("m_data", dat, (mq.size() > 0) ? mq[0] : 64'd0);
      chk("fifo_level", 64'(lvl), 64'(mq.size()));
      chk("spike_count", 64'(spk), 64'(m_spk));
      chk("overflow_count", 64'(ovf), 64'(m_ovf));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  initial begin
    logic [31:0] exp_ev [16];
    logic [31:0] last_ts;

    step(); step();
    rst = 1'b1;
    repeat (20) step();
    chk("idle_valid", 64'(vld), 64'd0);
    chk("idle_level", 64'(lvl), 64'd0);
    chk("idle_ovf", 64'(ovf), 64'd0);

    // Event 0->5 sampled when ts=10.
    rst = 1'b0; step();
    rst = 1'b1; rdy = 1'b1;
    repeat (10) step();
    ev = 32'd5; step();
    chk("first_valid", 64'(vld), 64'd1);
    chk("first_data", dat, 64'h0000000A_00000005);
    step();
    chk("after_pop_valid", 64'(vld), 64'd0);

    // Overflow: 20 changes into 16 slots.
    rdy = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      ev = 32'(i); step();
    end
    chk("full_level", 64'(lvl), 64'd16);
    chk("full_ovf", 64'(ovf), 64'd4);

    // Full with simultaneous pop and push.
    ev = 32'd21; rdy = 1'b1; step();
    chk("fullrw_level", 64'(lvl), 64'd16);
    chk("fullrw_ovf", 64'(ovf), 64'd4);
    chk("fullrw_head", 64'(dat[31:0]), 64'd2);

    for (int k = 0; k < 15; k++) exp_ev[k] = 32'(k + 2);
    exp_ev[15] = 32'd21;
    last_ts = 32'd0;
    for (int k = 0; k < 16; k++) begin
      chk("drain_event", 64'(dat[31:0]), 64'(exp_ev[k]));
      checks++;
      if (!(dat[63:32] > last_ts)) begin
        errors++;
        $display("FAIL drain_ts actual=%0d required_above=%0d", dat[63:32], last_ts);
      end
      last_ts = dat[63:32];
      step();
    end
    chk("drained_valid", 64'(vld), 64'd0);

    // Spike pattern 0,1,1,0,1.
    sp = 1'b0; step();
    sp = 1'b1; step();
    sp = 1'b1; step();
    sp = 1'b0; step();
    sp = 1'b1; step();
    sp = 1'b0; step();
    chk("spike_count2", 64'(spk), 64'd2);

    // Reset with three records pending.
    rdy = 1'b0;
    ev = 32'd100; step();
    ev = 32'd101; step();
    ev = 32'd102; step();
    chk("pre_rst_level", 64'(lvl), 64'd3);
    rst = 1'b0; step();
    chk("rst_valid", 64'(vld), 64'd0);
    chk("rst_level", 64'(lvl), 64'd0);
    chk("rst_spk", 64'(spk), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    rst = 1'b1; ev = 32'h77; step();
    chk("ts_restart", dat, 64'h00000000_00000077);
    chk("ts_restart_level", 64'(lvl), 64'd1);

    // Small instance: timestamp wrap and counter saturation.
    s_rst = 1'b0; step();
    s_rst = 1'b1;
    repeat (258) step();
    s_ev = 8'h5A; step();
    chk("small_ts_wrap", 64'(s_dat), 64'h025A);
    for (int i = 1; i <= 25; i++) begin
      s_ev = 8'(i); step();
    end
    chk("small_level", 64'(s_lvl), 64'd4);
    chk("small_ovf_sat", 64'(s_ovf), 64'd15);
    for (int i = 0; i < 20; i++) begin
      s_sp = 1'b1; step();
      s_sp = 1'b0; step();
    end
    chk("small_spk_sat", 64'(s_spk), 64'd15);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
